fifo_uart_tx: RTL and testbench

Serial transmit stage that sits directly downstream of the byte FIFO. When the FIFO is non-empty it pops one word, then shifts it out on a single line as an asynchronous-serial frame: start bit, data LSB first, optional even parity, stop bit. It is the consumer end of the FIFO, driving the FIFO's `read_enable` and taking its `empty` and `data_out`.

---
 rtl/fifo_uart_tx.sv | 123 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Serial transmitter that pops words from the upstream byte FIFO and sends each
// as an asynchronous frame: start, data LSB first, optional even parity, stop.
module fifo_uart_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_read_enable,
   output logic              tx_serial,
   output logic              busy,
   output logic              frame_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_POP, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;

   state_t            state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [BW-1:0]     bit_idx, bit_idx_n;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic              par, par_n;
   logic              rd_n, tx_n, busy_n, done_n;
   logic              bit_end;

   assign bit_end = (cnt == CNT_LAST);

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_idx_n = bit_idx;
      shreg_n   = shreg;
      par_n     = par;
      case (state)
         S_IDLE: if (!fifo_empty) state_n = S_POP;
         S_POP:  state_n = S_LOAD;
         S_LOAD: begin
            shreg_n   = fifo_data;
            par_n     = ^fifo_data;
            cnt_n     = '0;
            bit_idx_n = '0;
            state_n   = S_START;
         end
         S_START: begin
            if (bit_end) begin
               cnt_n   = '0;
               state_n = S_DATA;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_n   = '0;
               shreg_n = shreg >> 1;
               if (bit_idx == BIT_LAST) begin
                  bit_idx_n = '0;
                  state_n   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_idx_n = bit_idx + BW'(1);
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_PARITY, S_STOP: begin
            if (bit_end) begin
               cnt_n   = '0;
               state_n = (state == S_PARITY) ? S_STOP : S_IDLE;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: state_n = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they can be registered
      // yet still line up with the state they belong to.
      rd_n   = (state_n == S_POP);
      busy_n = (state_n != S_IDLE);
      done_n = (state_n == S_STOP) && (cnt_n == CNT_LAST);
      case (state_n)
         S_START:  tx_n = 1'b0;
         S_DATA:   tx_n = shreg_n[0];
         S_PARITY: tx_n = par_n;
         default:  tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= S_IDLE;
         cnt              <= '0;
         bit_idx          <= '0;
         shreg            <= '0;
         par              <= 1'b0;
         fifo_read_enable <= 1'b0;
         tx_serial        <= 1'b1;
         busy             <= 1'b0;
         frame_done       <= 1'b0;
      end else begin
         state            <= state_n;
         cnt              <= cnt_n;
         bit_idx          <= bit_idx_n;
         shreg            <= shreg_n;
         par              <= par_n;
         fifo_read_enable <= rd_n;
         tx_serial        <= tx_n;
         busy             <= busy_n;
         frame_done       <= done_n;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: one instance without parity, one with, each fed by a
// small FIFO model; frames are compared against a waveform built from the frame rules.
module tb_fifo_uart_tx;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       empty [2];
   logic [7:0] fdata [2] = '{8'h00, 8'h00};
   logic       rd    [2];
   logic       tx    [2];
   logic       busy  [2];
   logic       done  [2];

   logic [7:0] mem [2][16];
   int         wp  [2] = '{0, 0};
   int         rp  [2] = '{0, 0};

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [7:0] d;
      bit         par;
      int         exp_len;
      logic       exp_par;
   } vec_t;

   vec_t tab [7];

   always #5 clk = ~clk;

   assign empty[0] = (wp[0] == rp[0]);
   assign empty[1] = (wp[1] == rp[1]);

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rd[i] && (wp[i] != rp[i])) begin
            fdata[i] <= mem[i][rp[i] % 16];
            rp[i]    <= rp[i] + 1;
         end
      end
   end

   fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
      .clk(clk), .rst(rst), .fifo_empty(empty[0]), .fifo_data(fdata[0]),
      .fifo_read_enable(rd[0]), .tx_serial(tx[0]), .busy(busy[0]), .frame_done(done[0]));

   fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
      .clk(clk), .rst(rst), .fifo_empty(empty[1]), .fifo_data(fdata[1]),
      .fifo_read_enable(rd[1]), .tx_serial(tx[1]), .busy(busy[1]), .frame_done(done[1]));

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic push(input int p, input logic [7:0] d);
      mem[p][wp[p] % 16] = d;
      wp[p] = wp[p] + 1;
   endtask

   // Line waveform of one frame, one entry per clock, idle-high beyond the frame.
   function automatic logic [127:0] model_wave(input logic [7:0] d, input bit par, output int len);
      bit bits[$];
      logic [127:0] w;
      w = '1;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (par) bits.push_back(($countones(d) % 2) == 1);
      bits.push_back(1'b1);
      len = bits.size() * CPB;
      for (int c = 0; c < len; c++) w[c] = bits[c / CPB];
      return w;
   endfunction

   task automatic wait_pop(input int p, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         step();
         if (rd[p]) ok = 1'b1;
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL pop_timeout dut%0d: got no read_enable in 10 cycles, required one", p);
      end
   endtask

   // Called with the POP cycle just sampled.
   task automatic capture_frame(input int p, input logic [7:0] d, input bit par,
                                input bit use_tab, input int exp_len, input logic exp_par);
      logic [127:0] got_w, got_b, exp_w, exp_b;
      int len, first_done, ndone, nrd;
      step();
      chk("load_cycle", 128'({tx[p], busy[p], rd[p], done[p]}), 128'(4'b1100));
      got_w = '1;
      got_b = '0;
      first_done = -1;
      ndone = 0;
      nrd = 0;
      for (int c = 0; c < 64; c++) begin
         step();
         got_w[c] = tx[p];
         got_b[c] = busy[p];
         if (done[p]) begin
            ndone++;
            if (first_done < 0) first_done = c;
         end
         if (rd[p]) nrd++;
      end
      exp_w = model_wave(d, par, len);
      exp_b = '0;
      for (int c = 0; c < len; c++) exp_b[c] = 1'b1;
      chk("wave", got_w, exp_w);
      chk("busy", got_b, exp_b);
      chk("done_cycle", 128'(first_done + 1), 128'(len));
      chk("done_count", 128'(ndone), 128'(1));
      chk("extra_pops", 128'(nrd), 128'(0));
      if (use_tab) begin
         chk("frame_len", 128'(first_done + 1), 128'(exp_len));
         if (par) chk("parity_bit", 128'(got_w[9*CPB + 1]), 128'(exp_par));
      end
   endtask

   task automatic run_frame(input int p, input logic [7:0] d, input bit par,
                            input bit use_tab, input int exp_len, input logic exp_par);
      bit ok;
      push(p, d);
      wait_pop(p, ok);
      if (ok) capture_frame(p, d, par, use_tab, exp_len, exp_par);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish by 1 ms, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] got_tx, got_rd, exp_tx, exp_rd, w;
      bit ok;
      bit any_rd, any_low;
      int l1, l2, off2, p;
      logic [7:0] d;

      tab[0] = '{8'hA5, 1'b0, 40, 1'b0};
      tab[1] = '{8'h00, 1'b0, 40, 1'b0};
      tab[2] = '{8'h5A, 1'b0, 40, 1'b0};
      tab[3] = '{8'h07, 1'b1, 44, 1'b1};
      tab[4] = '{8'h03, 1'b1, 44, 1'b0};
      tab[5] = '{8'hFF, 1'b1, 44, 1'b0};
      tab[6] = '{8'h80, 1'b1, 44, 1'b1};

      // reset with a word already waiting
      rst = 1'b1;
      step();
      push(0, 8'h3C);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("reset_dut0", 128'({tx[0], rd[0], busy[0], done[0]}), 128'(4'b1000));
         chk("reset_dut1", 128'({tx[1], rd[1], busy[1], done[1]}), 128'(4'b1000));
      end
      rst = 1'b0;
      step();
      chk("pop_after_reset", 128'({rd[0], busy[0]}), 128'(2'b11));
      capture_frame(0, 8'h3C, 1'b0, 1'b0, 0, 1'b0);

      foreach (tab[i]) run_frame(tab[i].par ? 1 : 0, tab[i].d, tab[i].par, 1'b1, tab[i].exp_len, tab[i].exp_par);

      // back-to-back frames
      push(0, 8'h00);
      push(0, 8'hFF);
      wait_pop(0, ok);
      if (ok) begin
         got_tx = '1;
         got_rd = '0;
         got_tx[0] = tx[0];
         got_rd[0] = rd[0];
         for (int c = 1; c < 128; c++) begin
            step();
            got_tx[c] = tx[0];
            got_rd[c] = rd[0];
         end
         exp_tx = '1;
         exp_rd = '0;
         w = model_wave(8'h00, 1'b0, l1);
         for (int c = 0; c < l1; c++) exp_tx[2 + c] = w[c];
         off2 = 2 + l1 + 3;
         w = model_wave(8'hFF, 1'b0, l2);
         for (int c = 0; c < l2; c++) exp_tx[off2 + c] = w[c];
         exp_rd[0] = 1'b1;
         exp_rd[off2 - 2] = 1'b1;
         chk("b2b_wave", got_tx, exp_tx);
         chk("b2b_pops", got_rd, exp_rd);
         chk("b2b_empty", 128'(empty[0]), 128'(1));
      end

      // reset during data bit 3
      push(0, 8'hA5);
      wait_pop(0, ok);
      if (ok) begin
         step();
         for (int c = 0; c < 18; c++) step();
         chk("bit3_level", 128'(tx[0]), 128'(0));
         rst = 1'b1;
         push(0, 8'h96);
         step();
         chk("mid_reset", 128'({tx[0], busy[0], done[0], rd[0]}), 128'(4'b1000));
         rst = 1'b0;
         wait_pop(0, ok);
         if (ok) capture_frame(0, 8'h96, 1'b0, 1'b0, 0, 1'b0);
      end

      for (int i = 0; i < 16; i++) begin
         p = int'($urandom_range(0, 1));
         d = 8'($urandom_range(0, 255));
         run_frame(p, d, p != 0, 1'b0, 0, 1'b0);
      end

      // empty hold-off
      any_rd = 1'b0;
      any_low = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         any_rd = any_rd | rd[0] | rd[1];
         any_low = any_low | !tx[0] | !tx[1];
      end
      chk("holdoff_pops", 128'(any_rd), 128'(0));
      chk("holdoff_line", 128'(any_low), 128'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
